// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS fetch front end: fetch state encoding,
// PC width (word address [31:2]) and the default reset PC.
// -----------------------------------------------------------------------------
package mips_pkg;

  // PC is carried as a word address, bits [31:2] of the byte address.
  localparam int PC_W = 30;

  // Byte address of the first instruction fetched after reset.
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // request outstanding on imem, waiting for gnt
    ST_WAIT  = 2'd1,  // granted, waiting for rvalid
    ST_HOLD  = 2'd2,  // instruction presented to decode
    ST_ERR   = 2'd3   // fetch timed out (only reachable with FETCH_TIMEOUT_EN)
  } fetch_state_e;

  // Byte address to word address.
  function automatic logic [PC_W-1:0] byte_to_word(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_if
// Groups the instruction-memory port (req/gnt/rvalid) and the decode-side
// handshake (valid/ready) of the fetch stage.
//   master : fetch stage (drives imem_req/addr and id_valid/instr/pc)
//   slave  : memory + decode side (drives gnt/rvalid/rdata and id_ready)
// -----------------------------------------------------------------------------
interface pc_fetch_if;
  import mips_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            id_valid;
  logic [31:0]     id_instr;
  logic [PC_W-1:0] id_pc;
  logic            id_ready;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc,
    output imem_gnt, imem_rvalid, imem_rdata, id_ready
  );

endinterface

// File: rtl/fetch_timer.sv
// -----------------------------------------------------------------------------
// fetch_timer
// Counts fetch cycles (FETCH + WAIT) and flags expiry on the cycle in which
// the count reaches TIMEOUT_CYCLES.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   clr_i       clear counter (held while not fetching)
//   en_i        count this cycle
//   expired_o   this cycle is the TIMEOUT_CYCLES-th counted cycle
// -----------------------------------------------------------------------------
module fetch_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of cycles already counted, so LAST marks the
  // TIMEOUT_CYCLES-th one.
  assign expired_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
// Program-counter register and instruction-fetch stage. Fetches the word at
// pc over the imem req/gnt/rvalid port, presents it to decode, and loads
// npc_i as the new PC when decode retires it. One request outstanding max.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   pc_o         current PC [31:2]
//   npc_i        next PC [31:2], sampled only on retire
//   fetch_bus    pc_fetch_if.master (imem port + decode handshake)
//   fetch_err    sticky fetch timeout
// Optional feature: define FETCH_TIMEOUT_EN to enable the fetch timeout
// (ERR state, fetch_err). Without it fetch_err is tied low and a fetch waits
// forever.
// -----------------------------------------------------------------------------
module pc_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = RESET_PC_DEF,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   pc_o,
  input  logic [PC_W-1:0]   npc_i,
  pc_fetch_if.master        fetch_bus,
  output logic              fetch_err
);

  // Elaboration-time parameter sanity.
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("RESET_PC must be word aligned");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            timeout_s;

`ifdef FETCH_TIMEOUT_EN
  logic fetching_s;
  logic fetch_err_q;

  assign fetching_s = (state_q == ST_FETCH) || (state_q == ST_WAIT);

  fetch_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_fetch_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (!fetching_s),
    .en_i      (fetching_s),
    .expired_o (timeout_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      ST_FETCH: begin
        if (fetch_bus.imem_gnt) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (fetch_bus.imem_rvalid) begin
          instr_d = fetch_bus.imem_rdata;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (fetch_bus.id_ready) begin
          pc_d    = npc_i;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
    // A response arriving on the expiry cycle still completes the fetch.
    if (timeout_s && !(state_q == ST_WAIT && fetch_bus.imem_rvalid)) begin
      state_d = ST_ERR;
    end else begin
      state_d = state_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= byte_to_word(RESET_PC);
      instr_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Sticky error flag; ERR is only left through reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_err_q <= 1'b0;
    end else begin
      fetch_err_q <= (state_d == ST_ERR);
    end
  end
  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

  // Request/valid are gated by rst_n so nothing is driven while reset is held.
  assign fetch_bus.imem_req  = rst_n && (state_q == ST_FETCH);
  assign fetch_bus.imem_addr = pc_q;
  assign fetch_bus.id_valid  = rst_n && (state_q == ST_HOLD);
  assign fetch_bus.id_instr  = instr_q;
  assign fetch_bus.id_pc     = pc_q;
  assign pc_o                = pc_q;

endmodule
